// File: rtl/cpu_io_bridge.sv
// Sequences one (x, y) operand pair into the CPU's readyIn-strobed inport and samples
// the two result bytes from outport. Optional `CPU_IO_BRIDGE_CNT_EN adds a txn_count port.
module cpu_io_bridge #(
  parameter int n    = 8,
  parameter int HOLD = 5,
  parameter int GAP  = 20
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_x,
  input  logic [n-1:0] in_y,
  output logic [n:0]   cpu_in,
  input  logic [n-1:0] cpu_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [n-1:0] res_x,
  output logic [n-1:0] res_y
`ifdef CPU_IO_BRIDGE_CNT_EN
  ,
  output logic [15:0]  txn_count
`endif
);

  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_X_HI, S_X_LO, S_Y_HI, S_Y_LO, S_ACK_HI, S_GAP, S_RESULT
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_d;
  logic [n-1:0]  y_hold;

  logic          in_ready_d, res_valid_d, strobe_d, accept;
  logic [n-1:0]  data_d, res_x_d, res_y_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (in_valid && in_ready) next_state = S_X_HI;
      S_X_HI:   if (cnt == '0) next_state = S_X_LO;
      S_X_LO:   if (cnt == '0) next_state = S_Y_HI;
      S_Y_HI:   if (cnt == '0) next_state = S_Y_LO;
      S_Y_LO:   if (cnt == '0) next_state = S_ACK_HI;
      S_ACK_HI: if (cnt == '0) next_state = (GAP == 0) ? S_RESULT : S_GAP;
      S_GAP:    if (cnt == '0) next_state = S_RESULT;
      S_RESULT: if (res_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase

    cnt_d = cnt;
    if (next_state != state) begin
      unique case (next_state)
        S_GAP:             cnt_d = GAP_LD;
        S_IDLE, S_RESULT:  cnt_d = '0;
        default:           cnt_d = HOLD_LD;
      endcase
    end else if (cnt != '0) begin
      cnt_d = cnt - 1'b1;
    end
  end

  // Outputs are computed from the upcoming state and registered, so every pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    accept      = (state == S_IDLE) && (next_state == S_X_HI);
    in_ready_d  = (next_state == S_IDLE);
    res_valid_d = (next_state == S_RESULT);
    strobe_d    = (next_state == S_X_HI) || (next_state == S_Y_HI) ||
                  (next_state == S_ACK_HI);

    data_d = cpu_in[n-1:0];
    if (accept)
      data_d = in_x;
    else if ((state == S_X_LO) && (next_state == S_Y_HI))
      data_d = y_hold;

    res_x_d = res_x;
    res_y_d = res_y;
    if ((state == S_Y_LO) && (cnt == '0))
      res_x_d = cpu_out;
    if ((state == S_ACK_HI) && (cnt == '0))
      res_y_d = cpu_out;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      in_ready  <= 1'b1;
      cpu_in    <= '0;
      res_valid <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      y_hold    <= '0;
    end else begin
      in_ready  <= in_ready_d;
      cpu_in    <= {strobe_d, data_d};
      res_valid <= res_valid_d;
      res_x     <= res_x_d;
      res_y     <= res_y_d;
      if (accept)
        y_hold <= in_y;
    end
  end

`ifdef CPU_IO_BRIDGE_CNT_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)
      txn_count <= '0;
    else if ((state == S_RESULT) && res_ready)
      txn_count <= txn_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: CPU stub computing an affine transform, strobe-sequence
// table, capture points, back-pressure, back-to-back stream and HOLD=1/GAP=0 instance.
module tb_cpu_io_bridge;

  logic       clk = 1'b0;
  logic       nReset;
  logic       in_valid, res_ready;
  logic [7:0] in_x, in_y;
  logic [7:0] cpu_out = 8'hFF;
  logic       in_ready, res_valid;
  logic [8:0] cpu_in;
  logic [7:0] res_x, res_y;

  logic       in_valid1, res_ready1;
  logic [7:0] in_x1, in_y1;
  logic       in_ready1, res_valid1;
  logic [8:0] cpu_in1;
  logic [7:0] cpu_out1, res_x1, res_y1;

`ifdef CPU_IO_BRIDGE_CNT_EN
  logic [15:0] txn_count, txn_count1;
`endif

  always #5 clk = ~clk;

  cpu_io_bridge #(.n(8), .HOLD(5), .GAP(20)) dut (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .cpu_in(cpu_in), .cpu_out(cpu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y)
`ifdef CPU_IO_BRIDGE_CNT_EN
    , .txn_count(txn_count)
`endif
  );

  cpu_io_bridge #(.n(8), .HOLD(1), .GAP(0)) dut1 (
    .clk(clk), .nReset(nReset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_x(in_x1), .in_y(in_y1), .cpu_in(cpu_in1), .cpu_out(cpu_out1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_x(res_x1), .res_y(res_y1)
`ifdef CPU_IO_BRIDGE_CNT_EN
    , .txn_count(txn_count1)
`endif
  );

  // Output depends on the strobe level so the two capture points see different bytes.
  assign cpu_out1 = {cpu_in1[8], cpu_in1[6:0]} ^ 8'h55;

  // CPU stub: latches x and y on the first two strobes, presents x2 during Y_LO and
  // y2 during ACK_HI, 8'hFF elsewhere; stub_fixed swaps in the A5/3C pattern.
  int   rises = 0;
  logic last_strobe = 1'b0;
  bit   stub_fixed = 1'b0;
  int   sx, sy, rx, ry;

  always @(cpu_in or nReset) begin
    if (!nReset) begin
      rises = 0; last_strobe = 1'b0; cpu_out = 8'hFF;
    end else if (cpu_in[8] === 1'b1 && !last_strobe) begin
      last_strobe = 1'b1;
      rises++;
      if (rises == 1) sx = int'($signed(cpu_in[7:0]));
      else if (rises == 2) begin
        sy = int'($signed(cpu_in[7:0]));
        rx = ((3 * sx + 2 * sy) >>> 2) + 20;
        ry = ((3 * sy - 2 * sx) >>> 2) - 20;
      end
      cpu_out = (rises == 3) ? (stub_fixed ? 8'h3C : 8'(ry)) : 8'hFF;
    end else if (cpu_in[8] === 1'b0 && last_strobe) begin
      last_strobe = 1'b0;
      cpu_out = (rises == 2) ? (stub_fixed ? 8'hA5 : 8'(rx)) : 8'hFF;
      if (rises == 3) rises = 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  task automatic check_near(input string name, input int act, input int want);
    n_checks++;
    if (act - want <= 1 && want - act <= 1) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (+/-1)", name, act, want);
  endtask

  function automatic int gold_x(input int x, input int y);
    return int'(0.75 * x + 0.5 * y + 20.0);
  endfunction

  function automatic int gold_y(input int x, input int y);
    return int'(-0.5 * x + 0.75 * y - 20.0);
  endfunction

  typedef struct { int ex; int ey; } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int x, input int y);
    exp_t e;
    e.ex = gold_x(x, y);
    e.ey = gold_y(x, y);
    sb.push_back(e);
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_near({tag, " res_x"}, int'($signed(res_x)), e.ex);
      check_near({tag, " res_y"}, int'($signed(res_y)), e.ey);
    end
  endtask

  // Called at a negedge with in_ready high; returns at the negedge after the accept edge.
  task automatic start_pair(input logic [7:0] x, input logic [7:0] y);
    in_x = x; in_y = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!res_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) check({tag, " res_valid timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct { logic [8:0] cpu_in; int cycles; } seg_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    seg_t seq[6];
    bit   strobe1_exp[5];
    logic [8:0] seg_act;
    bit   seg_bad, early_valid;
    logic [7:0] hx, hy;
    bit   unstable_x, unstable_y, lost_valid, ready_seen;
    int   multi;

    seq[0] = '{9'h10A, 5};  seq[1] = '{9'h00A, 5};  seq[2] = '{9'h1F8, 5};
    seq[3] = '{9'h0F8, 5};  seq[4] = '{9'h1F8, 5};  seq[5] = '{9'h0F8, 20};
    strobe1_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    nReset = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_x = '0; in_y = '0;
    in_valid1 = 1'b0; res_ready1 = 1'b0; in_x1 = '0; in_y1 = '0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst cpu_in", cpu_in, 9'h000);
    check("rst res_valid", res_valid, 0);
    check("rst res_xy", {res_x, res_y}, 16'h0000);
    nReset = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", in_ready, 1);
    check("post-rst cpu_in", cpu_in, 9'h000);

    // Asynchronous reset at t0+7 mid-transaction.
    start_pair(8'd10, 8'hF8);
    repeat (7) @(negedge clk);
    nReset = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 1);
    check("midrst cpu_in", cpu_in, 9'h000);
    check("midrst res_valid", res_valid, 0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    // Strobe sequence for (10, -8), table-driven by segment.
    push_exp(10, -8);
    start_pair(8'd10, 8'hF8);
    early_valid = 1'b0;
    foreach (seq[i]) begin
      seg_bad = 1'b0;
      seg_act = seq[i].cpu_in;
      for (int c = 0; c < seq[i].cycles; c++) begin
        if (!seg_bad) seg_act = cpu_in;
        if (cpu_in !== seq[i].cpu_in) seg_bad = 1'b1;
        if (res_valid) early_valid = 1'b1;
        @(negedge clk);
      end
      check($sformatf("cpu_in segment %0d", i), seg_act, seq[i].cpu_in);
    end
    check("res_valid low before t0+45", early_valid, 0);
    check("res_valid at t0+45", res_valid, 1);
    pop_and_check("pair(10,-8)");
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("in_ready after handshake", in_ready, 1);
    check("res_valid after handshake", res_valid, 0);

    // Capture points with fixed stub pattern, then back-pressure in RESULT.
    stub_fixed = 1'b1;
    start_pair(8'h11, 8'h22);
    wait_valid("capture", 100);
    check("capture res_x", res_x, 8'hA5);
    check("capture res_y", res_y, 8'h3C);
    hx = res_x; hy = res_y;
    unstable_x = 1'b0; unstable_y = 1'b0; lost_valid = 1'b0; ready_seen = 1'b0;
    in_x = 8'h33; in_y = 8'h44; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_x !== hx) unstable_x = 1'b1;
      if (res_y !== hy) unstable_y = 1'b1;
      if (res_valid !== 1'b1) lost_valid = 1'b1;
      if (in_ready !== 1'b0) ready_seen = 1'b1;
    end
    check("bp res_x stable", unstable_x, 0);
    check("bp res_y stable", unstable_y, 0);
    check("bp res_valid held", lost_valid, 0);
    check("bp in_ready low", ready_seen, 0);
    res_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp release in_ready", in_ready, 1);
    stub_fixed = 1'b0;
`ifdef CPU_IO_BRIDGE_CNT_EN
    check("txn_count after 2", txn_count, 16'd2);
`endif

    // Ten random pairs streamed back-to-back with res_ready held high.
    res_ready = 1'b1;
    multi = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int x, y, k;
          x = int'($urandom_range(127)) - 64;
          y = int'($urandom_range(127)) - 64;
          in_x = 8'(x); in_y = 8'(y); in_valid = 1'b1;
          push_exp(x, y);
          k = 0;
          while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
          end
          if (!in_ready) check("stream accept timeout", 32'd0, 32'd1);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int got = 0, k = 0;
        bit prev = 1'b0;
        while (got < 10 && k < 1000) begin
          @(negedge clk);
          k++;
          if (res_valid) begin
            pop_and_check($sformatf("stream %0d", got));
            got++;
            if (prev) multi++;
          end
          prev = res_valid;
        end
        if (got < 10) check("stream result timeout", got, 10);
      end
    join
    check("RESULT one cycle with res_ready high", multi, 0);
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
`ifdef CPU_IO_BRIDGE_CNT_EN
    check("txn_count after 12", txn_count, 16'd12);
`endif

    // HOLD=1, GAP=0 instance: one cycle per phase, res_valid at t0+5.
    in_x1 = 8'h12; in_y1 = 8'hC3; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("h1 strobe t0+%0d", c), cpu_in1[8], strobe1_exp[c]);
      if (c == 4) check("h1 res_valid t0+4", res_valid1, 0);
      @(negedge clk);
    end
    check("h1 res_valid t0+5", res_valid1, 1);
    check("h1 res_x", res_x1, 8'h16);
    check("h1 res_y", res_y1, 8'h96);
    res_ready1 = 1'b1;
    @(negedge clk);
    res_ready1 = 1'b0;
    check("h1 in_ready after handshake", in_ready1, 1);
`ifdef CPU_IO_BRIDGE_CNT_EN
    check("h1 txn_count", txn_count1, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
